// File: rtl/icb_sram_mport.sv
// icb_sram_mport: NP ICB masters share one word-wide SRAM through a round-robin
// arbiter, with range/alignment error decode and a single registered response stage.
module icb_sram_mport #(
    parameter int NP        = 2,
    parameter int WIDTH     = 32,
    parameter int MW        = WIDTH / 8,
    parameter int ADDR_W    = 19,
    parameter int AW_LSB    = $clog2(MW),
    parameter int DP        = 131072,
    parameter int ALIGN_CHK = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NP-1:0]                          s_icb_cmd_valid,
    output logic [NP-1:0]                          s_icb_cmd_ready,
    input  logic [NP*ADDR_W-1:0]                   s_icb_cmd_addr,
    input  logic [NP-1:0]                          s_icb_cmd_read,
    input  logic [NP*WIDTH-1:0]                    s_icb_cmd_wdata,
    input  logic [NP*MW-1:0]                       s_icb_cmd_wmask,
    output logic [NP-1:0]                          s_icb_rsp_valid,
    input  logic [NP-1:0]                          s_icb_rsp_ready,
    output logic [NP*WIDTH-1:0]                    s_icb_rsp_rdata,
    output logic [NP-1:0]                          s_icb_rsp_err,
    output logic [((NP > 1) ? $clog2(NP) : 1)-1:0] arb_grant_id
);

    localparam int IDW = (NP > 1) ? $clog2(NP) : 1;
    localparam int WW  = ADDR_W - AW_LSB;
    localparam int MIW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [WW:0] DP_LIM = (WW + 1)'(DP);

    // Handshakes: a command or response transfers on a rising edge where its
    // valid and ready are both high; a master keeps valid and payload stable
    // until the transfer. cmd_ready may depend on the rsp_ready of whichever
    // port currently owns the response stage, never on any cmd_valid loop.

    logic [WIDTH-1:0] mem_q [DP];

    logic             rsp_full_q, rsp_full_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;

    logic [NP-1:0]     rot_valid;
    logic              found;
    logic [IDW-1:0]    sel_id;
    logic [IDW-1:0]    nxt_ptr;
    int                arb_off;
    int                arb_sum;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_read;
    logic [WIDTH-1:0]  sel_wdata;
    logic [MW-1:0]     sel_wmask;
    logic [WW-1:0]     dec_word;
    logic              dec_err;
    logic [MIW-1:0]    mem_idx;
    logic [NP-1:0]     rsp_oh;
    logic              rsp_fire;
    logic              can_accept;
    logic              accept;

    // Rotate the valids so the RR pointer sits at bit 0, then take the first set bit.
    always_comb begin
        rot_valid = NP'({s_icb_cmd_valid, s_icb_cmd_valid} >> rr_ptr_q);
        arb_off   = 0;
        for (int k = NP - 1; k >= 0; k--) begin
            if (rot_valid[k]) arb_off = k;
        end
        found   = |rot_valid;
        arb_sum = int'(rr_ptr_q) + arb_off;
        if (arb_sum >= NP) arb_sum = arb_sum - NP;
        sel_id  = IDW'(arb_sum);
        arb_sum = arb_sum + 1;
        if (arb_sum >= NP) arb_sum = 0;
        nxt_ptr = IDW'(arb_sum);
    end

    always_comb begin
        sel_addr  = '0;
        sel_read  = 1'b0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int i = 0; i < NP; i++) begin
            if (sel_id == IDW'(i)) begin
                sel_addr  = s_icb_cmd_addr[i*ADDR_W +: ADDR_W];
                sel_read  = s_icb_cmd_read[i];
                sel_wdata = s_icb_cmd_wdata[i*WIDTH +: WIDTH];
                sel_wmask = s_icb_cmd_wmask[i*MW +: MW];
            end
        end
    end

    assign dec_word = sel_addr[ADDR_W-1:AW_LSB];
    assign dec_err  = ({1'b0, dec_word} >= DP_LIM) |
                      ((ALIGN_CHK != 0) & (sel_addr[AW_LSB-1:0] != '0));
    assign mem_idx  = MIW'(dec_word);

    assign rsp_fire   = |(rsp_oh & s_icb_rsp_ready);
    assign can_accept = !rsp_full_q | rsp_fire;
    assign accept     = found & can_accept;

    for (genvar i = 0; i < NP; i++) begin : g_port
        assign rsp_oh[i]                         = rsp_full_q & (rsp_id_q == IDW'(i));
        assign s_icb_cmd_ready[i]                = accept & (sel_id == IDW'(i));
        assign s_icb_rsp_valid[i]                = rsp_oh[i];
        assign s_icb_rsp_rdata[i*WIDTH +: WIDTH] = rsp_oh[i] ? rsp_rdata_q : '0;
        assign s_icb_rsp_err[i]                  = rsp_oh[i] & rsp_err_q;
    end

    assign arb_grant_id = grant_q;

    // A fire and a new accept in the same cycle leave the stage full with the new entry.
    always_comb begin
        rsp_full_d  = rsp_full_q;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        if (rsp_fire) rsp_full_d = 1'b0;
        if (accept) begin
            rsp_full_d  = 1'b1;
            rsp_id_d    = sel_id;
            rsp_err_d   = dec_err;
            rsp_rdata_d = (sel_read && !dec_err) ? mem_q[mem_idx] : '0;
            rr_ptr_d    = nxt_ptr;
            grant_d     = sel_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_full_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
        end else begin
            rsp_full_q  <= rsp_full_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
        end
    end

    // Writes land in the accept cycle so a following read of the same word sees them.
    always_ff @(posedge clk) begin
        if (accept && !sel_read && !dec_err) begin
            for (int b = 0; b < MW; b++) begin
                if (sel_wmask[b]) mem_q[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_icb_sram_mport.sv
// Testbench for icb_sram_mport: a 4-port instance for directed and random traffic
// and a 1-port instance with alignment checking disabled.
module tb_icb_sram_mport;

    localparam int NPA = 4;
    localparam int W   = 32;
    localparam int AW  = 19;
    localparam int MW  = 4;
    localparam int DPT = 1024;
    localparam int NV  = 12;
    localparam int N_RAND = 10000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // ---------------- DUT A: 4 ports, alignment checked ----------------
    logic [NPA-1:0]    a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [NPA*AW-1:0] a_cmd_addr;
    logic [NPA*W-1:0]  a_cmd_wdata, a_rsp_rdata;
    logic [NPA*MW-1:0] a_cmd_wmask;
    logic [NPA-1:0]    a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [1:0]        a_grant;

    icb_sram_mport #(.NP(NPA), .WIDTH(W), .ADDR_W(AW), .DP(DPT), .ALIGN_CHK(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_icb_cmd_valid(a_cmd_valid), .s_icb_cmd_ready(a_cmd_ready),
        .s_icb_cmd_addr(a_cmd_addr), .s_icb_cmd_read(a_cmd_read),
        .s_icb_cmd_wdata(a_cmd_wdata), .s_icb_cmd_wmask(a_cmd_wmask),
        .s_icb_rsp_valid(a_rsp_valid), .s_icb_rsp_ready(a_rsp_ready),
        .s_icb_rsp_rdata(a_rsp_rdata), .s_icb_rsp_err(a_rsp_err),
        .arb_grant_id(a_grant)
    );

    // ---------------- DUT B: 1 port, low address bits ignored ----------------
    logic          b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [AW-1:0] b_cmd_addr;
    logic [W-1:0]  b_cmd_wdata, b_rsp_rdata;
    logic [MW-1:0] b_cmd_wmask;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [0:0]    b_grant;

    icb_sram_mport #(.NP(1), .WIDTH(W), .ADDR_W(AW), .DP(DPT), .ALIGN_CHK(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_icb_cmd_valid(b_cmd_valid), .s_icb_cmd_ready(b_cmd_ready),
        .s_icb_cmd_addr(b_cmd_addr), .s_icb_cmd_read(b_cmd_read),
        .s_icb_cmd_wdata(b_cmd_wdata), .s_icb_cmd_wmask(b_cmd_wmask),
        .s_icb_rsp_valid(b_rsp_valid), .s_icb_rsp_ready(b_rsp_ready),
        .s_icb_rsp_rdata(b_rsp_rdata), .s_icb_rsp_err(b_rsp_err),
        .arb_grant_id(b_grant)
    );

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_miss = 0;

    // {port[1:0], pad, err, rdata[31:0]} of the response expected next
    logic [35:0] exp_q[$];
    logic [31:0] ref_mem [16];

    typedef struct {
        logic        rd;
        int          port;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_a(input int p, input logic rd, input logic [18:0] addr,
                           input logic [31:0] wd, input logic [3:0] wm);
        a_cmd_valid[p]          = 1'b1;
        a_cmd_read[p]           = rd;
        a_cmd_addr[p*AW +: AW]  = addr;
        a_cmd_wdata[p*W +: W]   = wd;
        a_cmd_wmask[p*MW +: MW] = wm;
    endtask

    task automatic b_xact(input string nm, input logic rd, input logic [18:0] addr,
                          input logic [31:0] wd, input logic [3:0] wm,
                          input logic [31:0] er, input logic ee);
        @(negedge clk);
        b_cmd_valid = 1'b1;
        b_cmd_read  = rd;
        b_cmd_addr  = addr;
        b_cmd_wdata = wd;
        b_cmd_wmask = wm;
        #1;
        chk({nm, "_ready"}, b_cmd_ready, 1);
        @(negedge clk);
        b_cmd_valid = 1'b0;
        chk({nm, "_valid"}, b_rsp_valid, 1);
        chk({nm, "_rdata"}, b_rsp_rdata, er);
        chk({nm, "_err"}, b_rsp_err, ee);
        chk({nm, "_grant"}, b_grant, 0);
    endtask

    function automatic logic [18:0] rnd_addr();
        int k = $urandom_range(0, 9);
        int w = $urandom_range(0, 15);
        if (k == 0) return 19'(w * 4 + $urandom_range(1, 3));
        if (k == 1) return 19'((DPT + w) * 4);
        return 19'(w * 4);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [35:0] fe;
        int          fp;
        logic        busy, firing;
        int          acc_cnt, rsp_cnt, pend_port;
        int          wait_cnt [3];
        logic        just_acc [3];

        a_cmd_valid = '0; a_cmd_read = '0; a_cmd_addr = '0; a_cmd_wdata = '0;
        a_cmd_wmask = '0; a_rsp_ready = '1;
        b_cmd_valid = 1'b0; b_cmd_read = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
        b_cmd_wmask = '0; b_rsp_ready = 1'b1;

        vt[0]  = '{1'b0, 0, 19'h00100, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vt[1]  = '{1'b1, 0, 19'h00100, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b0, 0, 19'h00100, 32'h000000AA, 4'h1, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 0, 19'h00100, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vt[4]  = '{1'b1, 1, 19'h01000, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[5]  = '{1'b0, 2, 19'h00102, 32'h11223344, 4'hF, 32'h0,        1'b1};
        vt[6]  = '{1'b1, 3, 19'h00100, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vt[7]  = '{1'b0, 1, 19'h7FFFF, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vt[8]  = '{1'b0, 1, 19'h00FFC, 32'h12345678, 4'hF, 32'h0,        1'b0};
        vt[9]  = '{1'b0, 3, 19'h00FFC, 32'hCAFEF00D, 4'hA, 32'h0,        1'b0};
        vt[10] = '{1'b1, 2, 19'h00FFC, 32'h0,        4'h0, 32'hCA34F078, 1'b0};
        vt[11] = '{1'b1, 0, 19'h01004, 32'h0,        4'h0, 32'h0,        1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rsp_rdata", a_rsp_rdata, 0);
        chk("rst_rsp_err", a_rsp_err, 0);
        chk("rst_grant", a_grant, 0);
        chk("rst_b_rsp_valid", b_rsp_valid, 0);
        rst_n = 1'b1;

        // directed table, one command at a time
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_cmd_valid = '0;
            drive_a(vt[i].port, vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].wmask);
            #1;
            chk($sformatf("tbl%0d_ready", i), a_cmd_ready, 4'b1 << vt[i].port);
            @(negedge clk);
            a_cmd_valid = '0;
            chk($sformatf("tbl%0d_rsp_valid", i), a_rsp_valid, 4'b1 << vt[i].port);
            chk($sformatf("tbl%0d_rdata", i), a_rsp_rdata,
                {96'b0, vt[i].exp_rdata} << (32 * vt[i].port));
            chk($sformatf("tbl%0d_err", i), a_rsp_err, {3'b0, vt[i].exp_err} << vt[i].port);
            chk($sformatf("tbl%0d_grant", i), a_grant, vt[i].port);
        end

        // backpressure: port 0 response held, port 1 waits, then fire + accept together
        @(negedge clk);
        a_rsp_ready[0] = 1'b0;
        drive_a(0, 1'b1, 19'h00100, 32'h0, 4'h0);
        #1;
        chk("bp_first_ready", a_cmd_ready, 4'b0001);
        @(negedge clk);
        a_cmd_valid = '0;
        drive_a(1, 1'b1, 19'h00FFC, 32'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready_blocked", a_cmd_ready, 4'b0000);
            chk("bp_rsp_valid", a_rsp_valid, 4'b0001);
            chk("bp_rdata_stable", a_rsp_rdata, {96'b0, 32'hDEADBEAA});
            chk("bp_err_stable", a_rsp_err, 4'b0000);
            @(negedge clk);
        end
        a_rsp_ready[0] = 1'b1;
        #1;
        chk("bp_fire_accept", a_cmd_ready, 4'b0010);
        @(negedge clk);
        a_cmd_valid = '0;
        chk("bp_next_rsp_valid", a_rsp_valid, 4'b0010);
        chk("bp_next_rdata", a_rsp_rdata, {64'b0, 32'hCA34F078, 32'b0});

        // reset while a response is pending on port 2
        @(negedge clk);
        a_rsp_ready[2] = 1'b0;
        drive_a(2, 1'b1, 19'h00100, 32'h0, 4'h0);
        #1;
        chk("rm_ready", a_cmd_ready, 4'b0100);
        @(negedge clk);
        a_cmd_valid = '0;
        chk("rm_pending", a_rsp_valid, 4'b0100);
        chk("rm_grant_before", a_grant, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_rsp_valid", a_rsp_valid, 0);
        chk("rm_rsp_rdata", a_rsp_rdata, 0);
        chk("rm_grant", a_grant, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_rsp_ready = '1;

        // contention: all four ports valid, expect 0,1,2,3,0,... one per cycle
        @(negedge clk);
        for (int p = 0; p < NPA; p++) drive_a(p, 1'b1, 19'h00100, 32'h0, 4'h0);
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("cont%0d_ready", c), a_cmd_ready, 4'b1 << (c % 4));
            @(negedge clk);
            #1;
            chk($sformatf("cont%0d_rsp_valid", c), a_rsp_valid, 4'b1 << (c % 4));
            chk($sformatf("cont%0d_grant", c), a_grant, c % 4);
            chk($sformatf("cont%0d_rdata", c), a_rsp_rdata, {96'b0, 32'hDEADBEAA} << (32 * (c % 4)));
        end
        a_cmd_valid = '0;

        // single port, alignment ignored
        b_xact("b_wr_full", 1'b0, 19'h00100, 32'h11111111, 4'hF, 32'h0, 1'b0);
        b_xact("b_wr_0x102", 1'b0, 19'h00102, 32'h55667788, 4'hF, 32'h0, 1'b0);
        b_xact("b_rd_0x100", 1'b1, 19'h00100, 32'h0, 4'h0, 32'h55667788, 1'b0);
        b_xact("b_rd_0x103", 1'b1, 19'h00103, 32'h0, 4'h0, 32'h55667788, 1'b0);
        b_xact("b_rd_range", 1'b1, 19'h01000, 32'h0, 4'h0, 32'h0, 1'b1);
        b_xact("b_wr_range", 1'b0, 19'h01002, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);

        // preload the random working set so every read has a known value
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            @(negedge clk);
            drive_a(0, 1'b0, 19'(w * 4), ref_mem[w], 4'hF);
            #1;
            chk("pre_ready", a_cmd_ready, 4'b0001);
            @(negedge clk);
            a_cmd_valid = '0;
            chk("pre_err", a_rsp_err, 0);
        end

        // random traffic on ports 0..2 against the reference memory
        acc_cnt = 0; rsp_cnt = 0; pend_port = -1;
        for (int p = 0; p < 3; p++) begin
            wait_cnt[p] = 0;
            just_acc[p] = 1'b0;
        end
        for (int cyc = 0; cyc < 60000; cyc++) begin
            if (acc_cnt >= N_RAND && exp_q.size() == 0 && a_cmd_valid == '0) break;
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (!a_cmd_valid[p] || just_acc[p]) begin
                    a_cmd_valid[p] = 1'b0;
                    if (acc_cnt < N_RAND && $urandom_range(0, 3) != 0)
                        drive_a(p, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom));
                end
                a_rsp_ready[p] = (acc_cnt >= N_RAND) || ($urandom_range(0, 3) != 0);
                just_acc[p] = 1'b0;
            end
            #1;
            if (pend_port >= 0) chk("rnd_latency", a_rsp_valid[pend_port], 1);
            pend_port = -1;

            busy   = (exp_q.size() != 0);
            firing = 1'b0;
            fp     = 0;
            fe     = '0;
            if (busy) begin
                fe = exp_q[0];
                fp = int'(fe[35:34]);
                firing = a_rsp_ready[fp];
                chk("rnd_rsp_owner", a_rsp_valid, 4'b1 << fp);
            end else begin
                chk("rnd_no_rsp", a_rsp_valid, 0);
            end

            if (busy && !firing) chk("rnd_blocked", a_cmd_ready, 0);
            else if (a_cmd_valid == '0) chk("rnd_idle_ready", a_cmd_ready, 0);
            else begin
                chk("rnd_one_ready", $countones(a_cmd_ready), 1);
                chk("rnd_ready_valid", a_cmd_ready & ~a_cmd_valid, 0);
            end

            if (firing) begin
                void'(exp_q.pop_front());
                rsp_cnt++;
                chk("rnd_rdata", a_rsp_rdata[fp*W +: W], fe[31:0]);
                chk("rnd_err", a_rsp_err[fp], fe[32]);
            end

            for (int p = 0; p < 3; p++) begin
                if (a_cmd_valid[p] && a_cmd_ready[p]) begin
                    logic [18:0] addr;
                    logic [31:0] rd;
                    logic        err;
                    int          word;
                    addr = a_cmd_addr[p*AW +: AW];
                    word = int'(addr) / 4;
                    err  = (word >= DPT) || (int'(addr) % 4 != 0);
                    rd   = 32'h0;
                    if (!err) begin
                        if (a_cmd_read[p]) rd = ref_mem[word];
                        else for (int b = 0; b < MW; b++)
                            if (a_cmd_wmask[p*MW + b]) ref_mem[word][b*8 +: 8] = a_cmd_wdata[p*W + b*8 +: 8];
                    end
                    exp_q.push_back({2'(p), 1'b0, err, rd});
                    just_acc[p] = 1'b1;
                    pend_port = p;
                    acc_cnt++;
                    wait_cnt[p] = 0;
                    for (int q = 0; q < 3; q++) begin
                        if (q != p && a_cmd_valid[q]) begin
                            wait_cnt[q]++;
                            chk($sformatf("rnd_starve_p%0d", q), wait_cnt[q] < NPA, 1);
                        end
                    end
                end
            end
        end
        a_cmd_valid = '0;
        chk("rnd_all_accepted", acc_cnt >= N_RAND, 1);
        chk("rnd_rsp_count", rsp_cnt, acc_cnt);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
